// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares a single-port memory between the CPU core and a DMA /
//             loader port. Each requester uses a req/ack handshake. Ties are
//             broken round-robin. Only one memory operation is in flight at a
//             time: IDLE -> ISSUE -> WAIT (reads only) -> ACK -> IDLE.
//  Ports    : clk, reset              clock, synchronous active-high reset
//             cpu_req/we/addr/wdata   CPU request; held until cpu_ack
//             cpu_ack, cpu_rdata      CPU completion pulse, read data (held)
//             dma_*                   same set for the DMA / loader port
//             mem_en/we/addr/wdata    registered memory command
//             mem_rdata               memory read data, RD_LATENCY after issue
//             owner                   0 = CPU, 1 = DMA; current/last grant
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // RD_LATENCY is limited to 1..4, so the countdown fits in two bits.
    localparam logic [1:0] c_LAT_INIT = 2'(RD_LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_we;
    logic [1:0]          r_lat_cnt;
    logic                r_owner;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dma_rdata;

    logic                w_grant;
    logic                w_grant_dma;
    logic                w_capture;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_dma  = r_owner;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_grant      = 1'b1;
                    // On contention the port that did not own the last
                    // grant wins; otherwise the sole requester wins.
                    w_grant_dma  = (cpu_req && dma_req) ? ~r_owner : dma_req;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = r_we ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == 2'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                // Requests are deliberately not sampled here; the requester
                // re-presents in the following IDLE cycle.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
    assign w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command latch, latency counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_lat_cnt   <= 2'd0;
            r_owner     <= 1'b1;   // DMA as last owner lets the CPU win the first tie
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            // mem_en/mem_we are high only during the ISSUE cycle.
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;

            if (w_grant) begin
                r_owner     <= w_grant_dma;
                r_we        <= w_sel_we;
                r_mem_en    <= 1'b1;
                r_mem_we    <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end

            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= c_LAT_INIT;
            end else if ((r_state == ST_WAIT) && (r_lat_cnt != 2'd0)) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end

            if (w_capture) begin
                if (r_owner) begin
                    r_dma_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign cpu_ack   = (r_state == ST_ACK) && !r_owner;
    assign dma_ack   = (r_state == ST_ACK) &&  r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Requests push the expected
//             completion into per-port queues; a monitor pops and compares on
//             every ack. Expected read data comes from a reference memory
//             updated in request order per port (ports use disjoint regions
//             in concurrent phases).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [15:0] addr_v  [2];
    logic [7:0]  wdata_v [2];

    logic        cpu_ack, dma_ack, mem_en, mem_we, owner;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(req_v[0]), .cpu_we(we_v[0]), .cpu_addr(addr_v[0]), .cpu_wdata(wdata_v[0]),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(req_v[1]), .dma_we(we_v[1]), .dma_addr(addr_v[1]), .dma_wdata(wdata_v[1]),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Single-port memory, one-cycle registered read.
    logic [7:0] mem1    [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] rd_pipe1 = 8'h00;
    always @(posedge clk) begin
        if (mem_en && mem_we)  mem1[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe1 <= mem1[mem_addr];
    end
    assign mem_rdata = rd_pipe1;

    // Second instance with RD_LATENCY=3; its memory returns addr[7:0]^8'h5A.
    logic        r3_req = 1'b0;
    logic [15:0] r3_addr = 16'h0000;
    logic        r3_ack, r3_dack, r3_en, r3_we, r3_owner;
    logic [7:0]  r3_rdata, r3_drdata, r3_wdata, r3_mrdata;
    logic [15:0] r3_maddr;
    logic [7:0]  p3 [3];
    always @(posedge clk) begin
        p3[0] <= (r3_en && !r3_we) ? (r3_maddr[7:0] ^ 8'h5A) : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign r3_mrdata = p3[2];

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(r3_req), .cpu_we(1'b0), .cpu_addr(r3_addr), .cpu_wdata(8'h00),
        .cpu_ack(r3_ack), .cpu_rdata(r3_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(8'h00),
        .dma_ack(r3_dack), .dma_rdata(r3_drdata),
        .mem_en(r3_en), .mem_we(r3_we), .mem_addr(r3_maddr), .mem_wdata(r3_wdata),
        .mem_rdata(r3_mrdata), .owner(r3_owner)
    );

    exp_t cpu_q[$];
    exp_t dma_q[$];
    int   order_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] prev_rd0, prev_rd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ack(input int p, input logic [7:0] rd);
        exp_t e;
        int   o;
        n_cmp++;
        if ((p == 0 && cpu_q.size() == 0) || (p == 1 && dma_q.size() == 0)) begin
            n_bad++;
            $display("FAIL ack_unexpected: port %0d acked with nothing outstanding (cycle %0d)", p, cyc);
            return;
        end
        if (p == 0) e = cpu_q.pop_front();
        else        e = dma_q.pop_front();
        if (e.we) begin
            if (mem1[e.addr] !== e.data) begin
                n_bad++;
                $display("FAIL wr_commit port %0d addr %h: memory holds %h expected %h", p, e.addr, mem1[e.addr], e.data);
            end
        end else if (rd !== e.data) begin
            n_bad++;
            $display("FAIL rd_data port %0d addr %h: got %h expected %h", p, e.addr, rd, e.data);
        end
        if (order_q.size() > 0) begin
            o = order_q.pop_front();
            n_cmp++;
            if (o != p) begin
                n_bad++;
                $display("FAIL grant_order: port %0d acked, expected port %0d", p, o);
            end
        end
    endtask

    // Monitor: completions, ack exclusivity, rdata stability between acks.
    always @(negedge clk) begin
        if (cpu_ack && dma_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_excl: cpu_ack=1 dma_ack=1 expected at most one (cycle %0d)", cyc);
        end
        if (cpu_ack) check_ack(0, cpu_rdata);
        if (dma_ack) check_ack(1, dma_rdata);
        if (!reset) begin
            if (!cpu_ack && cpu_rdata !== prev_rd0) begin
                n_cmp++; n_bad++;
                $display("FAIL cpu_rdata_hold: got %h expected %h", cpu_rdata, prev_rd0);
            end
            if (!dma_ack && dma_rdata !== prev_rd1) begin
                n_cmp++; n_bad++;
                $display("FAIL dma_rdata_hold: got %h expected %h", dma_rdata, prev_rd1);
            end
        end
        prev_rd0 = cpu_rdata;
        prev_rd1 = dma_rdata;
    end

    // mode 0: hold req until ack; 1: drop req after grant; 2: also move addr to 16'h0400
    task automatic port_txn(input int p, input logic we, input logic [15:0] a, input logic [7:0] d,
                            input int mode, output int lat, output int en_cnt, output int en_first);
        exp_t e;
        int   start;
        bit   got;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : ref_mem[a];
        if (we) ref_mem[a] = d;
        if (p == 0) cpu_q.push_back(e);
        else        dma_q.push_back(e);
        we_v[p] = we; addr_v[p] = a; wdata_v[p] = d; req_v[p] = 1'b1;
        start = cyc; en_cnt = 0; en_first = -1; got = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                if (en_first < 0) en_first = cyc - start;
            end
            if ((p == 0 && cpu_ack) || (p == 1 && dma_ack)) begin
                got = 1'b1;
                lat = cyc - start;
            end
            @(posedge clk); #1;
            if (mode != 0) begin
                req_v[p] = 1'b0;
                if (mode == 2) addr_v[p] = 16'h0400;
            end
        end
        req_v[p] = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: port %0d no ack within 40 cycles", p);
        end
    endtask

    function automatic logic [15:0] rand_addr(input int p);
        logic [15:0] a;
        a = 16'($urandom);
        a[15] = (p == 1);
        if (p == 1 && $urandom_range(0, 7) == 0) a = 16'hFFFF;
        return a;
    endfunction

    task automatic rand_port(input int p, input int n, input bit gaps);
        int l, ec, ef;
        for (int k = 0; k < n; k++) begin
            port_txn(p, 1'($urandom_range(0, 1)), rand_addr(p), 8'($urandom), 0, l, ec, ef);
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int lat, ec, ef, l3;
        logic [15:0] a3;
        bit got3;
        for (int i = 0; i < 65536; i++) begin
            mem1[i]    = 8'($urandom);
            ref_mem[i] = mem1[i];
        end
        mem1[16'h8000] = 8'hA9; ref_mem[16'h8000] = 8'hA9;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = 16'h0000; wdata_v[p] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack,
                                cpu_rdata, dma_rdata, owner}, 64'd1);
        @(posedge clk); #1;

        // CPU read of 16'h8000, latency and single mem_en cycle
        port_txn(0, 1'b0, 16'h8000, 8'h00, 0, lat, ec, ef);
        check("cpu_rd_latency", lat, 3);
        check("cpu_rd_en_count", ec, 1);
        check("cpu_rd_en_cycle", ef, 1);

        // DMA write then CPU read of the same location
        port_txn(1, 1'b1, 16'h0200, 8'h55, 0, lat, ec, ef);
        check("dma_wr_latency", lat, 2);
        port_txn(0, 1'b0, 16'h0200, 8'h00, 0, lat, ec, ef);

        // Reset while a CPU read sits in WAIT: no ack, reset values restored
        we_v[0] = 1'b0; addr_v[0] = 16'h8000; req_v[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_mid_op", {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack,
                                   cpu_rdata, dma_rdata, owner}, 64'd1);
        end
        @(posedge clk); #1 reset = 1'b0;
        port_txn(0, 1'b0, 16'h8000, 8'h00, 0, lat, ec, ef);
        check("post_reset_rd_latency", lat, 3);

        // Address change after grant must not affect the operation
        port_txn(1, 1'b1, 16'h0300, 8'h11, 2, lat, ec, ef);
        check("dma_wr_drop_latency", lat, 2);
        check("addr_0400_untouched", mem1[16'h0400], ref_mem[16'h0400]);
        port_txn(0, 1'b0, 16'h0400, 8'h00, 0, lat, ec, ef);
        port_txn(1, 1'b0, 16'h0300, 8'h00, 0, lat, ec, ef);

        // CPU request withdrawn before it could be granted
        fork
            port_txn(1, 1'b1, 16'h9000, 8'h3C, 0, lat, ec, ef);
            begin
                @(posedge clk); #1;
                we_v[0] = 1'b1; addr_v[0] = 16'h0500; wdata_v[0] = 8'hEE; req_v[0] = 1'b1;
                @(posedge clk); #1;
                req_v[0] = 1'b0;
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        check("dropped_req_no_write", mem1[16'h0500], ref_mem[16'h0500]);

        // RD_LATENCY=3 instance: read of 16'hFFFF
        r3_addr = 16'hFFFF; r3_req = 1'b1;
        l3 = cyc; got3 = 1'b0; a3 = 16'h0000;
        for (int i = 0; i < 20 && !got3; i++) begin
            @(negedge clk);
            if (r3_en) a3 = r3_maddr;
            if (r3_ack) begin got3 = 1'b1; l3 = cyc - l3; end
            @(posedge clk); #1;
        end
        r3_req = 1'b0;
        check("lat3_acked", got3, 1);
        check("lat3_latency", l3, 5);
        check("lat3_rdata", r3_rdata, 8'hA5);
        check("lat3_mem_addr", a3, 16'hFFFF);

        // Both ports requesting back-to-back from reset: strict alternation
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) order_q.push_back(k % 2);
        fork
            rand_port(0, 4, 1'b0);
            rand_port(1, 4, 1'b0);
        join
        check("order_drained", order_q.size(), 0);

        // Randomized concurrent traffic
        fork
            rand_port(0, 40, 1'b1);
            rand_port(1, 40, 1'b1);
        join
        repeat (5) @(posedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("dma_q_drained", dma_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
